// File: rtl/cpu6502_pkg.sv
// Shared 6502 core types: interrupt sequence kinds and default vector addresses.
package cpu6502_pkg;

  typedef enum logic [1:0] {
    KIND_RESET = 2'b00,
    KIND_NMI   = 2'b01,
    KIND_IRQ   = 2'b10,
    KIND_BRK   = 2'b11
  } kind_e;

  localparam logic [15:0] NMI_VECTOR_DEF   = 16'hFFFA;
  localparam logic [15:0] RESET_VECTOR_DEF = 16'hFFFC;
  localparam logic [15:0] IRQ_VECTOR_DEF   = 16'hFFFE;

endpackage

// File: rtl/interrupt_sequencer_nmi_edge_detect.sv
// NMI falling-edge detector with a sticky pending flag; a fresh edge beats a clear.
module nmi_edge_detect (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clk_en,
  input  logic i_nmi_n,
  input  logic i_clear,
  output logic o_pending
);

  logic nmi_prev_q, nmi_prev_d;
  logic nmi_pending_q, nmi_pending_d;

  always_comb begin
    nmi_prev_d    = i_nmi_n;
    nmi_pending_d = (nmi_prev_q & ~i_nmi_n) | (nmi_pending_q & ~i_clear);
  end

  always_ff @(negedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      nmi_prev_q    <= 1'b1;
      nmi_pending_q <= 1'b0;
    end else if (i_clk_en) begin
      nmi_prev_q    <= nmi_prev_d;
      nmi_pending_q <= nmi_pending_d;
    end
  end

  assign o_pending = nmi_pending_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// 6502 interrupt/reset sequencer: picks the pending source at instruction boundaries
// and steers the forced BRK sequence (write suppression, B flag, vector address).
module interrupt_sequencer
  import cpu6502_pkg::*;
#(
  parameter logic [15:0] NMI_VECTOR   = NMI_VECTOR_DEF,
  parameter logic [15:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [15:0] IRQ_VECTOR   = IRQ_VECTOR_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_clk_en,
  input  logic        i_nmi_n,
  input  logic        i_irq_n,
  input  logic        i_i_flag,
  input  logic        i_sync,
  input  logic        i_last_cycle,
  input  logic        i_brk_decoded,
  input  logic        i_vector_next,
  input  logic        i_vector_hi,
  output logic        o_force_brk,
  output logic        o_suppress_write,
  output logic        o_b_flag,
  output logic [1:0]  o_kind,
  output logic [15:0] o_vector_addr
);

  logic  reset_pending_q, reset_pending_d;
  logic  irq_pending_q, irq_pending_d;
  logic  force_q, force_d;
  kind_e kind_q, kind_d;

  logic  nmi_pending;
  logic  nmi_clear;
  logic  decide;
  logic  hijack;
  kind_e kind_vec;

  nmi_edge_detect u_nmi_edge_detect (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clk_en  (i_clk_en),
    .i_nmi_n   (i_nmi_n),
    .i_clear   (nmi_clear),
    .o_pending (nmi_pending)
  );

  always_comb begin
    // The very first sync after reset is a decision point even without i_last_cycle.
    decide    = i_last_cycle | (i_sync & ~force_q & reset_pending_q);
    hijack    = i_vector_next & nmi_pending & ((kind_q == KIND_IRQ) | (kind_q == KIND_BRK));
    kind_vec  = hijack ? KIND_NMI : kind_q;
    nmi_clear = i_vector_next & (kind_vec == KIND_NMI);

    reset_pending_d = reset_pending_q;
    irq_pending_d   = ~i_irq_n & ~i_i_flag;
    force_d         = force_q;
    kind_d          = kind_vec;

    if (i_brk_decoded && !force_q) begin
      kind_d = KIND_BRK;
    end
    if (i_vector_hi) begin
      force_d = 1'b0;
    end
    // A decision on the sequence's final cycle chains straight into the next one.
    if (decide && (reset_pending_q || nmi_pending || irq_pending_q)) begin
      force_d = 1'b1;
      if (reset_pending_q) begin
        kind_d          = KIND_RESET;
        reset_pending_d = 1'b0;
      end else if (nmi_pending) begin
        kind_d = KIND_NMI;
      end else begin
        kind_d = KIND_IRQ;
      end
    end
  end

  always_ff @(negedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      reset_pending_q <= 1'b1;
      irq_pending_q   <= 1'b0;
      force_q         <= 1'b0;
      kind_q          <= KIND_RESET;
    end else if (i_clk_en) begin
      reset_pending_q <= reset_pending_d;
      irq_pending_q   <= irq_pending_d;
      force_q         <= force_d;
      kind_q          <= kind_d;
    end
  end

  always_comb begin
    case (kind_q)
      KIND_RESET: o_vector_addr = RESET_VECTOR;
      KIND_NMI:   o_vector_addr = NMI_VECTOR;
      default:    o_vector_addr = IRQ_VECTOR;
    endcase
  end

  assign o_force_brk      = force_q;
  assign o_suppress_write = force_q & (kind_q == KIND_RESET);
  assign o_b_flag         = (kind_q == KIND_BRK) & ~force_q;
  assign o_kind           = kind_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Randomised bench for interrupt_sequencer against a source-priority reference model,
// with a small instruction-stream generator producing the timing-unit strobes.
module tb_interrupt_sequencer;

  logic        i_clk, i_reset_n, i_clk_en, i_nmi_n, i_irq_n, i_i_flag;
  logic        i_sync, i_last_cycle, i_brk_decoded, i_vector_next, i_vector_hi;
  logic        o_force_brk, o_suppress_write, o_b_flag;
  logic [1:0]  o_kind;
  logic [15:0] o_vector_addr;

  interrupt_sequencer dut (
    .i_clk            (i_clk),
    .i_reset_n        (i_reset_n),
    .i_clk_en         (i_clk_en),
    .i_nmi_n          (i_nmi_n),
    .i_irq_n          (i_irq_n),
    .i_i_flag         (i_i_flag),
    .i_sync           (i_sync),
    .i_last_cycle     (i_last_cycle),
    .i_brk_decoded    (i_brk_decoded),
    .i_vector_next    (i_vector_next),
    .i_vector_hi      (i_vector_hi),
    .o_force_brk      (o_force_brk),
    .o_suppress_write (o_suppress_write),
    .o_b_flag         (o_b_flag),
    .o_kind           (o_kind),
    .o_vector_addr    (o_vector_addr)
  );

  localparam int K_RESET = 0;
  localparam int K_NMI   = 1;
  localparam int K_IRQ   = 2;
  localparam int K_BRK   = 3;

  int total = 0;
  int bad   = 0;
  int n_cyc = 0;

  // Reference model: pending sources indexed by priority (0 reset, 1 nmi, 2 irq).
  bit          m_pend [3];
  bit          m_pin_last;
  bit          m_force;
  int          m_kind;
  logic [15:0] vec_tbl [4];

  // Instruction-stream generator state.
  int pos;
  int len;
  bit seq;

  initial i_clk = 1'b1;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, n_cyc, got, exp);
    end
  endtask

  function automatic int pick_source();
    for (int i = 0; i < 3; i++) begin
      if (m_pend[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_pend[0]  = 1'b1;
    m_pend[1]  = 1'b0;
    m_pend[2]  = 1'b0;
    m_pin_last = 1'b1;
    m_force    = 1'b0;
    m_kind     = K_RESET;
  endtask

  task automatic model_step();
    int nk;
    int src;
    bit nf;
    bit clr;
    bit nmi_fell;
    bit decide;
    if (!i_clk_en) return;
    nmi_fell = m_pin_last && !i_nmi_n;
    nk = m_kind;
    if (i_vector_next && m_pend[1] && (m_kind == K_IRQ || m_kind == K_BRK)) nk = K_NMI;
    clr = i_vector_next && (nk == K_NMI);
    if (i_brk_decoded && !m_force) nk = K_BRK;
    nf = m_force && !i_vector_hi;
    decide = i_last_cycle || (i_sync && !m_force && m_pend[0]);
    src = pick_source();
    if (decide && src >= 0) begin
      nf = 1'b1;
      nk = src;
      if (src == K_RESET) m_pend[0] = 1'b0;
    end
    m_pend[1]  = nmi_fell || (m_pend[1] && !clr);
    m_pend[2]  = !i_irq_n && !i_i_flag;
    m_pin_last = i_nmi_n;
    m_force    = nf;
    m_kind     = nk;
  endtask

  task automatic check_outputs();
    check_val("force", 32'(o_force_brk), 32'(m_force));
    check_val("supw", 32'(o_suppress_write), 32'(m_force && m_kind == K_RESET));
    check_val("bflag", 32'(o_b_flag), 32'(m_kind == K_BRK && !m_force));
    check_val("kind", 32'(o_kind), 32'(m_kind));
    check_val("vec", 32'(o_vector_addr), 32'(vec_tbl[m_kind]));
  endtask

  task automatic step(input bit en, input bit nmi_n, input bit irq_n, input bit iflag,
                      input bit brk_req);
    i_clk_en = en;
    i_nmi_n  = nmi_n;
    i_irq_n  = irq_n;
    i_i_flag = iflag;
    if (en) begin
      if (pos == 0) begin
        len = $urandom_range(6, 2);
        seq = 1'b0;
      end
      if (pos == 1) begin
        seq = m_force || brk_req;
        if (seq) len = 7;
      end
      i_sync        = (pos == 0);
      i_brk_decoded = (pos == 1) && brk_req && !m_force;
      i_vector_next = seq && (pos == 4);
      i_vector_hi   = seq && (pos == 6);
      i_last_cycle  = (pos == len - 1);
    end else begin
      i_sync        = 1'($urandom_range(1, 0));
      i_brk_decoded = 1'($urandom_range(1, 0));
      i_vector_next = 1'($urandom_range(1, 0));
      i_vector_hi   = 1'($urandom_range(1, 0));
      i_last_cycle  = 1'($urandom_range(1, 0));
    end
    @(negedge i_clk);
    model_step();
    #1;
    n_cyc++;
    check_outputs();
    $display("cyc %0d en=%0b nmi_n=%0b irq_n=%0b I=%0b sync=%0b last=%0b vn=%0b vh=%0b force=%0b kind=%0d vec=%h",
             n_cyc, en, nmi_n, irq_n, iflag, i_sync, i_last_cycle, i_vector_next, i_vector_hi,
             o_force_brk, o_kind, o_vector_addr);
    if (en) begin
      pos++;
      if (pos >= len) pos = 0;
    end
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    #2;
    check_val("rst_force", 32'(o_force_brk), 32'd0);
    check_val("rst_supw", 32'(o_suppress_write), 32'd0);
    check_val("rst_bflag", 32'(o_b_flag), 32'd0);
    check_val("rst_kind", 32'(o_kind), 32'd0);
    check_val("rst_vec", 32'(o_vector_addr), 32'hFFFC);
    model_reset();
    pos = 0;
    len = 2;
    seq = 1'b0;
    @(negedge i_clk);
    #3;
    i_reset_n = 1'b1;
    $display("reset released at cyc %0d", n_cyc);
  endtask

  initial begin
    bit r_nmi;
    bit r_irq;
    bit r_if;
    vec_tbl[0] = 16'hFFFC;
    vec_tbl[1] = 16'hFFFA;
    vec_tbl[2] = 16'hFFFE;
    vec_tbl[3] = 16'hFFFE;
    i_reset_n = 1'b1; i_clk_en = 1'b1; i_nmi_n = 1'b1; i_irq_n = 1'b1; i_i_flag = 1'b1;
    i_sync = 1'b0; i_last_cycle = 1'b0; i_brk_decoded = 1'b0;
    i_vector_next = 1'b0; i_vector_hi = 1'b0;
    #1;
    do_reset();

    // First sync after reset forces the RESET sequence.
    step(1, 1, 1, 1, 0);
    check_val("first_force", 32'(o_force_brk), 32'd1);
    check_val("first_supw", 32'(o_suppress_write), 32'd1);
    check_val("first_vec", 32'(o_vector_addr), 32'hFFFC);
    repeat (6) step(1, 1, 1, 1, 0);
    check_val("rst_seq_end", 32'(o_force_brk), 32'd0);

    // Unmasked IRQ, then masked IRQ.
    repeat (20) step(1, 1, 0, 0, 0);
    repeat (12) step(1, 1, 1, 0, 0);
    repeat (20) step(1, 1, 0, 1, 0);
    repeat (12) step(1, 1, 1, 1, 0);

    // NMI held low across several instructions.
    repeat (30) step(1, 0, 1, 1, 0);
    repeat (12) step(1, 1, 1, 1, 0);

    // Software BRK hijacked by an NMI edge before the vector fetch.
    for (int k = 0; k < 20 && pos != 1; k++) step(1, 1, 1, 1, 0);
    step(1, 1, 1, 1, 1);
    check_val("brk_bflag", 32'(o_b_flag), 32'd1);
    check_val("brk_vec", 32'(o_vector_addr), 32'hFFFE);
    step(1, 0, 1, 1, 0);
    step(1, 0, 1, 1, 0);
    step(1, 0, 1, 1, 0);
    check_val("hijack_vec", 32'(o_vector_addr), 32'hFFFA);
    repeat (15) step(1, 0, 1, 1, 0);
    repeat (12) step(1, 1, 1, 1, 0);

    // NMI and IRQ together.
    repeat (30) step(1, 0, 0, 0, 0);
    repeat (12) step(1, 1, 1, 0, 0);

    // Reset asserted mid IRQ sequence while the clock enable is low.
    for (int k = 0; k < 60 && !(m_force && m_kind == K_IRQ); k++) step(1, 1, 0, 0, 0);
    check_val("irq_seq_reached", 32'(o_force_brk), 32'd1);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    do_reset();

    r_nmi = 1'b1;
    r_irq = 1'b1;
    r_if  = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(15, 0) == 0) r_nmi = !r_nmi;
      if ($urandom_range(9, 0) == 0) r_irq = !r_irq;
      if ($urandom_range(19, 0) == 0) r_if = !r_if;
      if ($urandom_range(399, 0) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(7, 0) != 0, r_nmi, r_irq, r_if, $urandom_range(5, 0) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
